// File: rtl/alu_stage_pkg.sv
// rtl/alu_stage_pkg.sv - shared types and defaults for the ALU result stage
// Holds the stage FSM encoding, default widths and the counter ceiling.
package alu_stage_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int B_W_DEF    = 4;
  localparam int CNT_W_DEF  = 4;

  localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter
// Ports: Clock, Reset_b (sync, active-low), inc (count one event), count (current value).
module sat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             Clock,
  input  logic             Reset_b,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX_VAL = '1;

  always_ff @(posedge Clock) begin
    if (!Reset_b) begin
      count <= '0;
    end else if (inc && (count != MAX_VAL)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered, handshaked output stage behind the 4-bit ALU
// Ports: Clock, Reset_b (sync, active-low); alu_in/in_valid/in_ready capture side;
// clr clears the held result; result/acc_b/out_valid/out_ready present the held value;
// op_count counts accepts (saturating); zero flags a held value of 0.
module alu_result_stage
  import alu_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int B_W    = B_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset_b,
  input  logic [DATA_W-1:0] alu_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clr,
  output logic [DATA_W-1:0] result,
  output logic [B_W-1:0]    acc_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  op_count,
  output logic              zero
);

  stage_state_t      state;
  logic [DATA_W-1:0] r_q;
  logic              zero_q;
  logic              accept;
  logic              count_inc;

  // Ready while FULL if the consumer drains this cycle, giving a pass-through accept.
  assign in_ready = (state == EMPTY) | out_ready;
  assign accept   = in_valid & in_ready;
  // clr drops a concurrent accept, so it must not be counted either.
  assign count_inc = accept & ~clr;

  always_ff @(posedge Clock) begin
    if (!Reset_b) begin
      state  <= EMPTY;
      r_q    <= '0;
      zero_q <= 1'b1;
    end else if (clr) begin
      state  <= EMPTY;
      r_q    <= '0;
      zero_q <= 1'b1;
    end else if (accept) begin
      state  <= FULL;
      r_q    <= alu_in;
      zero_q <= (alu_in == '0);
    end else if ((state == FULL) && out_ready) begin
      // Drained: R is retained so the display keeps the last value.
      state <= EMPTY;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_op_counter (
    .Clock   (Clock),
    .Reset_b (Reset_b),
    .inc     (count_inc),
    .count   (op_count)
  );

  assign result    = r_q;
  // Taken from the register so the ALU->stage->ALU loop is always broken by R.
  assign acc_b     = r_q[B_W-1:0];
  assign out_valid = (state == FULL);
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage
module tb_alu_result_stage;

  logic       Clock;
  logic       Reset_b;
  logic [7:0] alu_in;
  logic       in_valid;
  logic       in_ready;
  logic       clr;
  logic [7:0] result;
  logic [3:0] acc_b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] op_count;
  logic       zero;

  int tests_run = 0;
  int fails     = 0;

  // Reference model: held value, occupancy and a plain integer count.
  int  m_r    = 0;
  bit  m_full = 0;
  int  m_cnt  = 0;

  logic seen_ready;
  logic exp_ready;

  alu_result_stage dut (
    .Clock     (Clock),
    .Reset_b   (Reset_b),
    .alu_in    (alu_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clr       (clr),
    .result    (result),
    .acc_b     (acc_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op_count  (op_count),
    .zero      (zero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step(input logic rb, input logic iv, input logic [7:0] d,
                      input logic ordy, input logic c);
    bit rdy;
    Reset_b   = rb;
    in_valid  = iv;
    alu_in    = d;
    out_ready = ordy;
    clr       = c;
    #1;
    seen_ready = in_ready;
    rdy        = !m_full || ordy;
    exp_ready  = rdy;
    @(posedge Clock);
    if (!rb) begin
      m_r = 0; m_full = 0; m_cnt = 0;
    end else if (c) begin
      m_r = 0; m_full = 0;
    end else if (iv && rdy) begin
      m_r = int'(d); m_full = 1;
      m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
    end else if (m_full && ordy) begin
      m_full = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    step(0, 1, 8'hA5, 0, 0);
    step(0, 1, 8'hA5, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    tests_run++; if (result !== 8'h00) begin fails++; $display("FAIL reset_result got %h want 00", result); end
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++; if (zero !== 1'b1) begin fails++; $display("FAIL reset_zero got %b want 1", zero); end
    tests_run++; if (op_count !== 4'h0) begin fails++; $display("FAIL reset_op_count got %h want 0", op_count); end
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_capture_hold();
    step(1, 1, 8'h1C, 0, 0);
    tests_run++; if (result !== 8'h1C) begin fails++; $display("FAIL cap_result got %h want 1c", result); end
    tests_run++; if (acc_b !== 4'hC) begin fails++; $display("FAIL cap_acc_b got %h want c", acc_b); end
    tests_run++; if (out_valid !== 1'b1) begin fails++; $display("FAIL cap_out_valid got %b want 1", out_valid); end
    tests_run++; if (op_count !== 4'h1) begin fails++; $display("FAIL cap_op_count got %h want 1", op_count); end
    tests_run++; if (zero !== 1'b0) begin fails++; $display("FAIL cap_zero got %b want 0", zero); end
    step(1, 1, 8'h33, 0, 0);
    tests_run++; if (seen_ready !== 1'b0) begin fails++; $display("FAIL hold_in_ready got %b want 0", seen_ready); end
    tests_run++; if (result !== 8'h1C) begin fails++; $display("FAIL hold_result got %h want 1c", result); end
    tests_run++; if (op_count !== 4'h1) begin fails++; $display("FAIL hold_op_count got %h want 1", op_count); end
  endtask

  task automatic test_pass_through();
    step(1, 1, 8'h07, 1, 0);
    tests_run++; if (seen_ready !== 1'b1) begin fails++; $display("FAIL pt_in_ready got %b want 1", seen_ready); end
    tests_run++; if (result !== 8'h07) begin fails++; $display("FAIL pt_result got %h want 07", result); end
    tests_run++; if (out_valid !== 1'b1) begin fails++; $display("FAIL pt_out_valid got %b want 1", out_valid); end
    tests_run++; if (op_count !== 4'h2) begin fails++; $display("FAIL pt_op_count got %h want 2", op_count); end
  endtask

  task automatic test_drain();
    step(1, 0, 8'h55, 1, 0);
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_out_valid got %b want 0", out_valid); end
    tests_run++; if (result !== 8'h07) begin fails++; $display("FAIL drain_result got %h want 07", result); end
    tests_run++; if (acc_b !== 4'h7) begin fails++; $display("FAIL drain_acc_b got %h want 7", acc_b); end
  endtask

  task automatic test_accumulate();
    logic [7:0] sum;
    step(1, 0, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) begin
      // ALU function 000: A + B, 4-bit operands zero-extended into 8 bits.
      sum = 8'(4'h3) + 8'(acc_b);
      step(1, 1, sum, 1, 0);
      tests_run++;
      if (result !== 8'(3 * (i + 1))) begin
        fails++; $display("FAIL accum_%0d got %h want %h", i, result, 8'(3 * (i + 1)));
      end
    end
  endtask

  task automatic test_clr_vs_accept();
    logic [3:0] cnt_before;
    step(1, 1, 8'h42, 0, 0);
    cnt_before = 4'(m_cnt);
    step(1, 1, 8'hFF, 0, 1);
    tests_run++; if (result !== 8'h00) begin fails++; $display("FAIL clr_result got %h want 00", result); end
    tests_run++; if (zero !== 1'b1) begin fails++; $display("FAIL clr_zero got %b want 1", zero); end
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL clr_out_valid got %b want 0", out_valid); end
    tests_run++; if (op_count !== cnt_before) begin fails++; $display("FAIL clr_op_count got %h want %h", op_count, cnt_before); end
  endtask

  task automatic test_saturation();
    step(0, 0, 8'h00, 0, 0);
    for (int i = 1; i <= 17; i++) begin
      step(1, 1, 8'h01, 1, 0);
      if (i == 14) begin
        tests_run++; if (op_count !== 4'hE) begin fails++; $display("FAIL sat_14 got %h want e", op_count); end
      end
      if (i == 15) begin
        tests_run++; if (op_count !== 4'hF) begin fails++; $display("FAIL sat_15 got %h want f", op_count); end
      end
    end
    tests_run++; if (op_count !== 4'hF) begin fails++; $display("FAIL sat_17 got %h want f", op_count); end
    tests_run++; if (result !== 8'h01) begin fails++; $display("FAIL sat_result got %h want 01", result); end
  endtask

  task automatic test_mid_reset();
    step(1, 1, 8'h9A, 0, 0);
    step(0, 1, 8'h77, 1, 0);
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    tests_run++; if (result !== 8'h00) begin fails++; $display("FAIL midrst_result got %h want 00", result); end
    tests_run++; if (op_count !== 4'h0) begin fails++; $display("FAIL midrst_op_count got %h want 0", op_count); end
    tests_run++; if (zero !== 1'b1) begin fails++; $display("FAIL midrst_zero got %b want 1", zero); end
  endtask

  task automatic test_random();
    logic       rb, iv, ordy, c;
    logic [7:0] d;
    for (int i = 0; i < 300; i++) begin
      rb   = ($urandom_range(0, 49) != 0);
      iv   = $urandom_range(0, 1);
      ordy = ($urandom_range(0, 2) != 0);
      c    = ($urandom_range(0, 15) == 0);
      d    = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      step(rb, iv, d, ordy, c);
      tests_run++;
      if (seen_ready !== exp_ready || result !== 8'(m_r) || acc_b !== 4'(m_r % 16) ||
          out_valid !== m_full || zero !== (m_r == 0) || op_count !== 4'(m_cnt)) begin
        fails++;
        $display("FAIL rand_%0d got rdy=%b r=%h b=%h v=%b z=%b c=%h want rdy=%b r=%h b=%h v=%b z=%b c=%h",
                 i, seen_ready, result, acc_b, out_valid, zero, op_count,
                 exp_ready, 8'(m_r), 4'(m_r % 16), m_full, (m_r == 0), 4'(m_cnt));
      end
    end
  endtask

  initial begin
    Reset_b = 1'b0; in_valid = 1'b0; alu_in = '0; out_ready = 1'b0; clr = 1'b0;
    test_reset();
    test_capture_hold();
    test_pass_through();
    test_drain();
    test_accumulate();
    test_clr_vs_accept();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
